// File: rtl/k12a_spi_slave.sv
// k12a_spi_slave -- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first).
//
// The SPI pins are asynchronous to cpu_clock. They are oversampled through
// 2-flop synchronisers. A third flop on sck and cs_n provides edge detection,
// so a pin edge becomes an internal event three cpu_clock cycles later.
// The host side is a byte interface. A TX holding register is consumed at
// every byte boundary, and an RX holding register carries valid/ack
// handshaking plus a sticky overrun flag.
//
// Ports:
//   cpu_clock, reset_n      system clock, asynchronous active-low reset
//   spi_sck/cs_n/mosi       SPI pins from the master (asynchronous)
//   spi_miso, spi_miso_oe   serial data to the master and its output enable
//   tx_data, tx_write       host byte to send and its load strobe
//   tx_pending              TX holding register not yet consumed
//   rx_data, rx_valid       last received byte and its valid flag
//   rx_ack                  host strobe that clears rx_valid
//   overrun, overrun_clear  sticky "byte lost while rx_valid" flag and its clear
//   busy                    selected with a byte partly shifted
module k12a_spi_slave #(
  parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx_pending,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  input  logic       overrun_clear,
  output logic       busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;

  // In each pipe, [0] is the metastability flop, [1] is the synchronised
  // level, and [2] is the previous synchronised level for edge detection.
  logic [2:0]  sck_pipe;
  logic [2:0]  cs_pipe;
  logic [1:0]  mosi_pipe;

  logic        sck_rise, sck_fall, cs_fall, cs_rise, mosi_sync;

  logic [7:0]  tx_hold;
  logic [7:0]  tx_shift;
  logic [7:0]  tx_load_byte;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic [2:0]  bit_cnt;

  logic        load_tx, shift_tx, sample_rx, byte_done, select, deselect;

  // ---------------------------------------------------------------------
  // Pin synchronisers. Reset to the idle bus levels (sck low, cs_n high)
  // so that releasing reset never fabricates an edge.
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours and the synchroniser chain
  // really is three stages long.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_pipe  <= 3'b000;
      cs_pipe   <= 3'b111;
      mosi_pipe <= 2'b00;
    end else begin
      sck_pipe  <= {sck_pipe[1:0], spi_sck};
      cs_pipe   <= {cs_pipe[1:0], spi_cs_n};
      mosi_pipe <= {mosi_pipe[0], spi_mosi};
    end
  end

  assign sck_rise  =  sck_pipe[1] & ~sck_pipe[2];
  assign sck_fall  = ~sck_pipe[1] &  sck_pipe[2];
  assign cs_fall   = ~cs_pipe[1]  &  cs_pipe[2];
  assign cs_rise   =  cs_pipe[1]  & ~cs_pipe[2];
  assign mosi_sync =  mosi_pipe[1];

  // Byte that any shift-register load uses. A tx_write in the same cycle
  // only updates tx_hold afterwards, so the old contents are loaded.
  assign tx_load_byte = tx_pending ? tx_hold : TX_IDLE_BYTE;
  assign rx_byte      = {rx_shift, mosi_sync};

  // ---------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first. Otherwise, a path
  // that does not assign it would infer a latch.
  always_comb begin
    state_d   = state_q;
    load_tx   = 1'b0;
    shift_tx  = 1'b0;
    sample_rx = 1'b0;
    select    = 1'b0;
    deselect  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // SCK edges are ignored here. Only a select wakes the responder.
        if (cs_fall) begin
          state_d = ACTIVE;
          select  = 1'b1;
          load_tx = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect wins over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          state_d  = IDLE;
          deselect = 1'b1;
        end else begin
          sample_rx = sck_rise;
          if (sck_fall) begin
            // The falling edge after the 8th bit (count wrapped to 0) sets
            // up the next byte of a burst instead of shifting.
            if (bit_cnt == 3'd0) load_tx  = 1'b1;
            else                 shift_tx = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_done = sample_rx && (bit_cnt == 3'd7);
  assign busy      = (state_q == ACTIVE) && (bit_cnt != 3'd0);

  // ---------------------------------------------------------------------
  // Transmit path: holding register, shift register, MISO driver
  // ---------------------------------------------------------------------
  // NOTE: the data registers (tx_hold, tx_shift, rx_shift) are reset
  // together with the control flops. They are small, and a known value keeps
  // MISO defined if the master clocks before the host has written anything.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_hold     <= 8'h00;
      tx_pending  <= 1'b0;
      tx_shift    <= 8'h00;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      // A write during a load re-arms pending for the next byte boundary.
      if (tx_write) begin
        tx_hold    <= tx_data;
        tx_pending <= 1'b1;
      end else if (load_tx) begin
        tx_pending <= 1'b0;
      end

      if (load_tx)       tx_shift <= tx_load_byte;
      else if (shift_tx) tx_shift <= {tx_shift[6:0], 1'b0};

      if (select) begin
        spi_miso_oe <= 1'b1;
        spi_miso    <= tx_load_byte[7];
      end else if (deselect) begin
        spi_miso_oe <= 1'b0;
        spi_miso    <= 1'b0;
      end else if (state_q == ACTIVE) begin
        spi_miso    <= tx_shift[7];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Receive path: bit counter, shift register, holding register, overrun
  // ---------------------------------------------------------------------
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // Partial bits are discarded on deselect simply by zeroing the count.
      // rx_shift is fully refilled before its next use.
      if (select || deselect) bit_cnt <= 3'd0;
      else if (sample_rx)     bit_cnt <= bit_cnt + 3'd1;

      if (sample_rx) rx_shift <= rx_byte[6:0];

      // An ack in the same cycle as completion frees the slot in time.
      if (byte_done && (!rx_valid || rx_ack)) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      // A new overrun event takes priority over a simultaneous clear.
      if (byte_done && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (overrun_clear)               overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_k12a_spi_slave.sv
// tb_k12a_spi_slave -- self-checking bench for k12a_spi_slave.
// The bench acts as a bit-banged mode-0 SPI master plus the host.
// The run has four parts:
//   1. A table of single-byte transactions with hand-derived expectations.
//   2. Hand-written sequences for bursts, overrun, abort, same-cycle strobes
//      and asynchronous reset.
//   3. Randomized bursts.
//   4. A byte-level reference model that tracks the randomized bursts.
module tb_k12a_spi_slave;

  localparam int HALF   = 8;  // SCK half period in cpu_clock cycles
  localparam int SETTLE = 5;  // cycles for a pin edge to be fully processed

  logic       cpu_clock = 1'b0;
  logic       reset_n;
  logic       spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_pending;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       overrun;
  logic       overrun_clear;
  logic       busy;

  int checks = 0;
  int errors = 0;

  k12a_spi_slave #(.TX_IDLE_BYTE(8'hFF)) dut (
    .cpu_clock     (cpu_clock),
    .reset_n       (reset_n),
    .spi_sck       (spi_sck),
    .spi_cs_n      (spi_cs_n),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .tx_data       (tx_data),
    .tx_write      (tx_write),
    .tx_pending    (tx_pending),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .overrun       (overrun),
    .overrun_clear (overrun_clear),
    .busy          (busy)
  );

  always #5 cpu_clock = ~cpu_clock;

  typedef struct {
    logic       wr;         // host writes wdata before select
    logic [7:0] wdata;
    logic [7:0] mosi;       // byte sent by the master
    logic       ack_before; // host acks rx before select
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[5];

  // Reference model: transaction-level view of the holding registers.
  logic       m_pend;
  logic [7:0] m_hold;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] b);
    @(negedge cpu_clock); tx_data = b; tx_write = 1'b1;
    @(negedge cpu_clock); tx_write = 1'b0;
  endtask

  task automatic host_ack();
    @(negedge cpu_clock); rx_ack = 1'b1;
    @(negedge cpu_clock); rx_ack = 1'b0;
  endtask

  task automatic host_clear_ovr();
    @(negedge cpu_clock); overrun_clear = 1'b1;
    @(negedge cpu_clock); overrun_clear = 1'b0;
  endtask

  // Select. When write_at_load is set, tx_write is timed to land exactly on
  // the select load: pin edge + 3 cycles.
  task automatic cs_low(input logic write_at_load, input logic [7:0] wd);
    @(negedge cpu_clock); spi_cs_n = 1'b0;
    if (write_at_load) begin
      @(posedge cpu_clock); @(posedge cpu_clock);
      @(negedge cpu_clock); tx_data = wd; tx_write = 1'b1;
      @(negedge cpu_clock); tx_write = 1'b0;
    end
    repeat (HALF) @(negedge cpu_clock);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge cpu_clock);
    spi_cs_n = 1'b1;
    repeat (SETTLE) @(negedge cpu_clock);
  endtask

  // One full byte. MISO is sampled at each SCK pin rise.
  // When ack_at_done is set, rx_ack pulses on the cycle the 8th rise is acted
  // on (the rise + 3 cycles). valid_early is rx_valid 4 cycles after the
  // 8th rise.
  task automatic xfer_byte(input logic [7:0] mosi_b, input logic ack_at_done,
                           output logic [7:0] miso_b, output logic valid_early);
    miso_b      = 8'h00;
    valid_early = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge cpu_clock); spi_mosi = mosi_b[i];
      repeat (HALF - 1) @(negedge cpu_clock);
      spi_sck   = 1'b1;
      miso_b[i] = spi_miso;
      if (i == 0) begin
        if (ack_at_done) begin
          @(posedge cpu_clock); @(posedge cpu_clock);
          @(negedge cpu_clock); rx_ack = 1'b1;
          @(negedge cpu_clock); rx_ack = 1'b0;
          @(negedge cpu_clock);
        end else begin
          repeat (4) @(negedge cpu_clock);
        end
        valid_early = rx_valid;
        repeat (HALF - 4) @(negedge cpu_clock);
      end else begin
        repeat (HALF) @(negedge cpu_clock);
      end
      spi_sck = 1'b0;
    end
    repeat (SETTLE) @(negedge cpu_clock);
  endtask

  task automatic xfer_bits(input logic [7:0] mosi_b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge cpu_clock); spi_mosi = mosi_b[i];
      repeat (HALF - 1) @(negedge cpu_clock);
      spi_sck = 1'b1;
      repeat (HALF) @(negedge cpu_clock);
      spi_sck = 1'b0;
    end
    repeat (SETTLE) @(negedge cpu_clock);
  endtask

  // Model: a byte boundary consumes the held byte or the idle filler.
  task automatic model_load(output logic [7:0] b);
    b      = m_pend ? m_hold : 8'hFF;
    m_pend = 1'b0;
  endtask

  task automatic model_rx(input logic [7:0] b, input logic acked);
    if (!m_valid || acked) begin
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] miso_b, exp_b, wd, mb;
    logic       early, ackd;
    int         nb;

    reset_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_data = 8'h00; tx_write = 1'b0; rx_ack = 1'b0; overrun_clear = 1'b0;
    repeat (3) @(negedge cpu_clock);
    check("reset miso",       spi_miso, 0);
    check("reset miso_oe",    spi_miso_oe, 0);
    check("reset tx_pending", tx_pending, 0);
    check("reset rx_data",    rx_data, 0);
    check("reset rx_valid",   rx_valid, 0);
    check("reset overrun",    overrun, 0);
    check("reset busy",       busy, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge cpu_clock);

    // ---------------- table of single-byte transactions ----------------
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'h5A, 1'b1, 8'hFF, 8'h5A, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'h81, 1'b1, 8'h00, 8'h81, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h7E, 8'hC3, 1'b0, 8'h7E, 8'h81, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'h96, 8'h00, 1'b1, 8'h96, 8'h00, 1'b1, 1'b1};
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].ack_before) host_ack();
      if (vecs[v].wr) host_write(vecs[v].wdata);
      cs_low(1'b0, 8'h00);
      check($sformatf("vec%0d busy idle", v), busy, 0);
      check($sformatf("vec%0d miso_oe", v), spi_miso_oe, 1);
      xfer_byte(vecs[v].mosi, 1'b0, miso_b, early);
      cs_high();
      check($sformatf("vec%0d miso byte", v), miso_b, vecs[v].exp_miso);
      check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_rx);
      check($sformatf("vec%0d rx_valid", v), rx_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d overrun", v), overrun, vecs[v].exp_ovr);
      check($sformatf("vec%0d tx_pending", v), tx_pending, 0);
      check($sformatf("vec%0d miso_oe off", v), spi_miso_oe, 0);
      if (v == 0) check("single rx_valid within 4", early, 1);
    end
    host_clear_ovr();
    check("overrun cleared", overrun, 0);

    // ---------------- burst with underrun ----------------
    host_ack();
    host_write(8'h5A);
    cs_low(1'b0, 8'h00);
    xfer_byte(8'h11, 1'b0, miso_b, early);
    check("burst miso0", miso_b, 8'h5A);
    check("burst rx0", rx_data, 8'h11);
    host_ack();
    xfer_byte(8'h22, 1'b0, miso_b, early);
    check("burst miso1 underrun", miso_b, 8'hFF);
    check("burst rx1", rx_data, 8'h22);
    check("burst overrun", overrun, 0);
    cs_high();

    // ---------------- overrun ----------------
    host_ack();
    cs_low(1'b0, 8'h00);
    xfer_byte(8'h01, 1'b0, miso_b, early);
    xfer_byte(8'h02, 1'b0, miso_b, early);
    cs_high();
    check("ovr rx_data", rx_data, 8'h01);
    check("ovr flag", overrun, 1);
    host_clear_ovr();
    check("ovr cleared", overrun, 0);

    // ---------------- abort after 5 bits ----------------
    cs_low(1'b0, 8'h00);
    xfer_bits(8'hF0, 5);
    check("abort busy mid-byte", busy, 1);
    host_write(8'h42);
    cs_high();
    check("abort rx_valid", rx_valid, 1);
    check("abort rx_data", rx_data, 8'h01);
    check("abort busy", busy, 0);
    check("abort miso_oe", spi_miso_oe, 0);
    check("abort miso", spi_miso, 0);
    check("abort tx kept", tx_pending, 1);
    host_ack();
    cs_low(1'b0, 8'h00);
    xfer_byte(8'hC3, 1'b0, miso_b, early);
    cs_high();
    check("after abort miso", miso_b, 8'h42);
    check("after abort rx", rx_data, 8'hC3);
    check("after abort overrun", overrun, 0);

    // ---------------- rx_ack coincident with completion ----------------
    cs_low(1'b0, 8'h00);
    xfer_byte(8'h5E, 1'b1, miso_b, early);
    cs_high();
    check("coinc ack rx_data", rx_data, 8'h5E);
    check("coinc ack rx_valid", rx_valid, 1);
    check("coinc ack overrun", overrun, 0);

    // ---------------- tx_write coincident with the select load ----------------
    cs_low(1'b1, 8'h99);
    check("coinc write pending", tx_pending, 1);
    xfer_byte(8'h00, 1'b1, miso_b, early);
    check("coinc write old byte", miso_b, 8'hFF);
    xfer_byte(8'h00, 1'b1, miso_b, early);
    check("coinc write new byte", miso_b, 8'h99);
    cs_high();
    check("coinc write overrun", overrun, 0);

    // ---------------- asynchronous reset mid-burst ----------------
    host_write(8'h55);
    cs_low(1'b0, 8'h00);
    xfer_bits(8'hAA, 3);
    check("pre-reset busy", busy, 1);
    #3 reset_n = 1'b0;
    #1;
    check("async reset miso",       spi_miso, 0);
    check("async reset miso_oe",    spi_miso_oe, 0);
    check("async reset tx_pending", tx_pending, 0);
    check("async reset rx_data",    rx_data, 0);
    check("async reset rx_valid",   rx_valid, 0);
    check("async reset overrun",    overrun, 0);
    check("async reset busy",       busy, 0);
    spi_cs_n = 1'b1; spi_sck = 1'b0;
    repeat (3) @(negedge cpu_clock);
    reset_n = 1'b1;
    repeat (10) @(negedge cpu_clock);
    check("post-reset rx_valid", rx_valid, 0);
    check("post-reset miso_oe", spi_miso_oe, 0);

    // ---------------- randomized bursts vs reference model ----------------
    m_pend = 1'b0; m_hold = 8'h00; m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        wd = 8'($urandom); host_write(wd); m_pend = 1'b1; m_hold = wd;
        if ($urandom_range(3, 0) == 0) begin
          wd = 8'($urandom); host_write(wd); m_hold = wd;
        end
      end
      if ($urandom_range(2, 0) == 0) begin host_ack(); m_valid = 1'b0; end
      if ($urandom_range(3, 0) == 0) begin host_clear_ovr(); m_ovr = 1'b0; end
      cs_low(1'b0, 8'h00);
      model_load(exp_b);
      nb = $urandom_range(3, 1);
      for (int b = 0; b < nb; b++) begin
        mb   = 8'($urandom);
        ackd = ($urandom_range(2, 0) == 0);
        xfer_byte(mb, ackd, miso_b, early);
        model_rx(mb, ackd);
        check($sformatf("rnd%0d.%0d miso", t, b), miso_b, exp_b);
        check($sformatf("rnd%0d.%0d rx_data", t, b), rx_data, m_data);
        check($sformatf("rnd%0d.%0d rx_valid", t, b), rx_valid, m_valid);
        check($sformatf("rnd%0d.%0d overrun", t, b), overrun, m_ovr);
        model_load(exp_b);
        if ($urandom_range(2, 0) == 0) begin
          wd = 8'($urandom); host_write(wd); m_pend = 1'b1; m_hold = wd;
        end
        if ($urandom_range(1, 0) == 0) begin host_ack(); m_valid = 1'b0; end
      end
      cs_high();
      check($sformatf("rnd%0d tx_pending", t), tx_pending, m_pend);
      check($sformatf("rnd%0d busy", t), busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/k12a_spi_slave.md
Name: k12a_spi_slave

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first). It is the device end of the link driven by the K12a SPI master.
- Oversamples the external SPI pins on cpu_clock and synchronises them internally.
- Host side is a byte interface: one TX holding register and one RX holding register with valid/ack.
- Used for board-to-board links and for loopback verification of the SPI master.

Parameters:
- TX_IDLE_BYTE, 8'hFF, byte shifted out when no TX byte is pending at byte load (underrun filler).

Ports:
- cpu_clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- spi_sck  input  1  serial clock from the master; asynchronous to cpu_clock.
- spi_cs_n  input  1  chip select from the master, active low; asynchronous.
- spi_mosi  input  1  serial data from the master; asynchronous.
- spi_miso  output  1  serial data to the master.
- spi_miso_oe  output  1  MISO output enable; 1 while selected.
- tx_data  input  8  byte to transmit.
- tx_write  input  1  single-cycle strobe that loads tx_data into the TX holding register.
- tx_pending  output  1  TX holding register contains a byte not yet consumed.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unacknowledged byte.
- rx_ack  input  1  single-cycle strobe that clears rx_valid.
- overrun  output  1  sticky: a byte completed while rx_valid=1.
- overrun_clear  input  1  clears overrun.
- busy  output  1  selected and a byte is in progress (bit count != 0).

Behaviour:
- Clock and reset: one clock (cpu_clock); reset is asynchronous and active-low (reset_n).
- Reset values: spi_miso=0, spi_miso_oe=0, tx_pending=0, rx_data=8'h00, rx_valid=0, overrun=0, busy=0, state=IDLE, bit count=0. Both synchronisers reset to idle levels (sck=0, cs_n=1).
- Synchronisation: spi_sck, spi_cs_n and spi_mosi each pass through a 2-flop synchroniser. A third flop on sck and on cs_n provides edge detection. Pin edge to internal event = 3 cycles.
- Timing requirements on the master: SCK high and low phases ≥4 cpu_clock cycles each; ≥4 cycles from CS_n fall to the first SCK rise.
- State machine, IDLE to ACTIVE: on a detected cs_n falling edge.
  - Load tx_shift with the TX holding register if tx_pending=1, otherwise TX_IDLE_BYTE.
  - Clear tx_pending; bit count=0; spi_miso_oe=1; spi_miso=tx_shift[7].
- ACTIVE, sck rising edge: rx_shift <= {rx_shift[6:0], mosi_sync}; count++.
- ACTIVE, 8th sck rising edge: the completed byte {rx_shift[6:0], mosi_sync} is handled as follows.
  - If rx_valid=0, or rx_ack is asserted in the same cycle: rx_data <= byte, rx_valid=1.
  - Otherwise: the byte is dropped, rx_data is unchanged, and overrun <= 1.
  - Count wraps to 0.
- ACTIVE, sck falling edge:
  - If count=0 (byte boundary): reload tx_shift exactly as on select, which supports multi-byte bursts.
  - Otherwise: tx_shift <= tx_shift << 1.
  - spi_miso follows tx_shift[7] on the cycle after the update.
- ACTIVE to IDLE: on a detected cs_n rising edge, including mid-byte.
  - Partial RX bits are discarded; rx_valid and rx_data are unaffected.
  - Count=0; spi_miso_oe=0; spi_miso=0.
  - Any pending TX byte is kept.
- busy = (state==ACTIVE) && (count!=0).
- TX holding register: tx_write sets the register and tx_pending=1. A write while pending overwrites the held byte.
- tx_write in the same cycle as a shift-register load: the load uses the old register contents (or TX_IDLE_BYTE if nothing was pending). The new byte stays pending for the next byte boundary.
- rx_ack with rx_valid=0: no effect.
- overrun_clear and a new overrun event in the same cycle: overrun stays 1.
- SCK edges while in IDLE are ignored.

Test Plan:
- Reset: assert reset_n=0 mid-burst. Required: all outputs at reset values immediately (asynchronously); no spurious rx_valid after release.
- Single byte: tx_write 8'hA5; master selects and sends 8'h3C. Required: master receives 8'hA5; rx_data=8'h3C, rx_valid=1 ≤4 cycles after the 8th SCK rise; tx_pending=0.
- Burst with underrun: master sends 8'h11,8'h22 under one CS with only 8'h5A written. Required: MISO returns 8'h5A then 8'hFF. Host acks between bytes; rx_data sequence 11,22; overrun=0.
- Overrun: two bytes 8'h01,8'h02 with no rx_ack. Required: rx_data=8'h01, overrun=1. overrun_clear then returns overrun=0.
- Abort: CS_n rises after 5 bits. Required: rx_valid unchanged, busy=0, spi_miso_oe=0. The next full transfer of 8'hC3 is received correctly.
- Same-cycle cases: rx_ack coincident with byte completion gives rx_valid=1 with no overrun. tx_write coincident with the reload gives the old/idle byte sent, with the new byte on the following byte.
